// File: rtl/cache_pkg.sv
// Shared types, widths and address field helpers for the direct-mapped data cache.
package cache_pkg;

  localparam int DEF_NUM_LINES      = 32;
  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_LINE_W         = 32 * DEF_WORDS_PER_LINE;

  localparam int OFFSET_W = $clog2(DEF_WORDS_PER_LINE);
  localparam int INDEX_W  = $clog2(DEF_NUM_LINES);
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[OFFSET_W+2 +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] addr);
    return addr[2 +: OFFSET_W];
  endfunction

  // Rebuilds a line-aligned byte address from its tag and index.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [INDEX_W-1:0] index);
    return {tag, index, {(OFFSET_W+2){1'b0}}};
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data arrays for the data cache: one combinational read port,
// one write port that takes either a single word (store) or a whole line (refill).
module cache_line_store
  import cache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int LINE_W         = DEF_LINE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic                word_we,
  input  logic [31:0]         word_data,
  input  logic                line_we,
  input  logic [TAG_W-1:0]    line_tag,
  input  logic [LINE_W-1:0]   line_data,
  input  logic                clean_we
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

  // Only the status bits are reset; stale tags are harmless once valid is clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[wr_index] <= 1'b1;
    end else if (clean_we) begin
      dirty_q[wr_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[wr_index] <= line_tag;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        data_q[wr_index][w] <= line_data[w*32 +: 32];
      end
    end else if (word_we) begin
      data_q[wr_index][wr_offset] <= word_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];

  always_comb begin
    rd_line = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      rd_line[w*32 +: 32] = data_q[rd_index][w];
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits answer in the same cycle; misses stall the pipeline while a writeback and/or refill runs.
module data_cache_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int LINE_W         = DEF_LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_t state_q;
  state_t state_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                active;
  logic                is_load;
  logic                hit;

  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic [31:0]         rd_word;

  logic                word_we;
  logic                line_we;
  logic                clean_we;
  logic                load_hit;
  logic [31:0]         data_q;
  logic                unused_addr_bits;

  assign req_tag    = addr_tag(addr_i);
  assign req_index  = addr_index(addr_i);
  assign req_offset = addr_offset(addr_i);
  assign unused_addr_bits = ^addr_i[1:0];

  // A simultaneous read+write request is a store, so only a pure read is a load.
  assign active  = MemRead_i | MemWrite_i;
  assign is_load = MemRead_i & ~MemWrite_i;
  assign hit     = rd_valid && (rd_tag == req_tag);
  assign rd_word = rd_line[{req_offset, 5'b0} +: 32];

  cache_line_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .LINE_W         (LINE_W)
  ) u_store (
    .clk       (clk_i),
    .rst       (rst_i),
    .rd_index  (req_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_index  (req_index),
    .wr_offset (req_offset),
    .word_we   (word_we),
    .word_data (data_i),
    .line_we   (line_we),
    .line_tag  (req_tag),
    .line_data (mem_rdata_i),
    .clean_we  (clean_we)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (active && !hit) begin
          state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array writes are suppressed during reset so a late ack cannot revalidate a line.
  always_comb begin
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    load_hit    = 1'b0;
    word_we     = 1'b0;
    line_we     = 1'b0;
    clean_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o  = active & ~hit;
        load_hit = is_load & hit;
        word_we  = MemWrite_i & hit & ~rst_i;
      end
      WRITEBACK: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = line_addr(rd_tag, req_index);
        mem_wdata_o = rd_line;
        clean_we    = mem_ack_i & ~rst_i;
      end
      ALLOCATE: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = line_addr(req_tag, req_index);
        line_we    = mem_ack_i & ~rst_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_hit) begin
      data_q <= rd_word;
    end
  end

  assign data_o = load_hit ? rd_word : data_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl: a word-level reference memory predicts load data,
// a line-level backing memory answers the handshake with a programmable ack delay.
module tb_data_cache_ctrl;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [31:0]  data_i;
  logic         MemRead_i;
  logic         MemWrite_i;
  logic [31:0]  data_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;

  int total = 0;
  int bad   = 0;

  int ack_delay  = 0;
  bit resp_hold  = 0;
  bit stray_ack  = 0;
  int hold_viol  = 0;

  logic [31:0]  exp_q[$];
  bit           log_we[$];
  logic [31:0]  log_addr[$];
  logic [255:0] log_wdata[$];

  logic [31:0]  ref_mem [logic [31:0]];
  logic [255:0] bmem    [logic [31:0]];

  data_cache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .data_o      (data_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] initWord(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa == 32'h40) return 32'hCAFE_F00D;
    if (wa == 32'h44) return 32'h1234_5678;
    return wa ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] refWord(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return initWord(wa);
  endfunction

  function automatic logic [255:0] getLine(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    l = '0;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = initWord(la + 32'(w * 4));
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pops the oldest serviced memory request and checks its direction and address.
  task automatic checkReq(input string tag, input bit exp_we, input logic [31:0] exp_addr,
                          output logic [255:0] wdata);
    bit          we;
    logic [31:0] a;
    if (log_addr.size() == 0) begin
      checkOutput({tag, "_present"}, 256'd0, 256'd1);
      wdata = '0;
    end else begin
      we    = log_we.pop_front();
      a     = log_addr.pop_front();
      wdata = log_wdata.pop_front();
      checkOutput({tag, "_we"}, {255'd0, we}, {255'd0, exp_we});
      checkOutput({tag, "_addr"}, {224'd0, a}, {224'd0, exp_addr});
    end
  endtask

  // Backing memory: acks on the (ack_delay+1)-th cycle of a request and checks request stability.
  initial begin
    int  wait_cnt;
    bit  in_req;
    bit  cap_we;
    logic [31:0]  cap_addr;
    logic [255:0] cap_wdata;
    wait_cnt = 0;
    in_req = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (stray_ack) begin
        mem_ack_i = 1'b1;
        stray_ack = 0;
      end else if (mem_req_o && !resp_hold) begin
        if (!in_req) begin
          in_req = 1;
          wait_cnt = 0;
          cap_we = mem_we_o;
          cap_addr = mem_addr_o;
          cap_wdata = mem_wdata_o;
        end else if (mem_we_o !== cap_we || mem_addr_o !== cap_addr || mem_wdata_o !== cap_wdata) begin
          hold_viol++;
        end
        if (wait_cnt >= ack_delay) begin
          if (mem_we_o) bmem[mem_addr_o] = mem_wdata_o;
          else mem_rdata_i = getLine(mem_addr_o);
          log_we.push_back(mem_we_o);
          log_addr.push_back(mem_addr_o);
          log_wdata.push_back(mem_wdata_o);
          mem_ack_i = 1'b1;
          in_req = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        in_req = 0;
      end
    end
  end

  // Drives one access, waits (bounded) for stall to fall, then scores load data.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, output int stalls);
    int n;
    logic [31:0] exp;
    @(negedge clk_i);
    MemRead_i = rd;
    MemWrite_i = wr;
    addr_i = addr;
    data_i = wdata;
    if (rd && !wr) exp_q.push_back(refWord(addr));
    n = 0;
    #1;
    while (stall_o && n < 200) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (stall_o) checkOutput("stall_timeout", 256'd1, 256'd0);
    stalls = n;
    if (rd && !wr) begin
      exp = exp_q.pop_front();
      checkOutput("load_data", {224'd0, data_o}, {224'd0, exp});
    end
    if (wr) ref_mem[{addr[31:2], 2'b00}] = wdata;
    @(posedge clk_i);
    #1;
    MemRead_i = 0;
    MemWrite_i = 0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    logic [255:0] wd;
    rst_i = 1'b1;
    MemRead_i = 0;
    MemWrite_i = 0;
    addr_i = '0;
    data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("rst_stall", {255'd0, stall_o}, 256'd0);
    checkOutput("rst_req", {255'd0, mem_req_o}, 256'd0);
    checkOutput("rst_we", {255'd0, mem_we_o}, 256'd0);
    checkOutput("rst_addr", {224'd0, mem_addr_o}, 256'd0);
    checkOutput("rst_wdata", mem_wdata_o, 256'd0);
    checkOutput("rst_data", {224'd0, data_o}, 256'd0);

    $display("[TB] cold load, clean miss");
    ack_delay = 3;
    applyStimulus(1, 0, 32'h40, 32'h0, st);
    checkOutput("t1_stalls", 256'(st), 256'd5);
    checkReq("t1_alloc", 0, 32'h40, wd);
    applyStimulus(1, 0, 32'h44, 32'h0, st);
    checkOutput("t1_hit_stalls", 256'(st), 256'd0);

    $display("[TB] write hit then read hit");
    applyStimulus(0, 1, 32'h44, 32'hDEAD_BEEF, st);
    checkOutput("t2_store_stalls", 256'(st), 256'd0);
    applyStimulus(1, 0, 32'h44, 32'h0, st);
    checkOutput("t2_load_stalls", 256'(st), 256'd0);
    checkOutput("t2_no_req", 256'(log_addr.size()), 256'd0);
    @(negedge clk_i);
    #1;
    checkOutput("t2_data_hold", {224'd0, data_o}, {224'd0, 32'hDEAD_BEEF});

    $display("[TB] dirty eviction");
    ack_delay = 1;
    applyStimulus(1, 0, 32'h444, 32'h0, st);
    checkOutput("t3_stalls", 256'(st), 256'd5);
    checkReq("t3_wb", 1, 32'h40, wd);
    checkOutput("t3_wb_word1", {224'd0, wd[63:32]}, {224'd0, 32'hDEAD_BEEF});
    checkReq("t3_alloc", 0, 32'h440, wd);
    applyStimulus(1, 0, 32'h44, 32'h0, st);
    checkOutput("t3_refetch_stalls", 256'(st), 256'd3);
    checkReq("t3_refetch", 0, 32'h40, wd);

    $display("[TB] handshake hold and stray ack");
    applyStimulus(0, 1, 32'h444, 32'h0BAD_F00D, st);
    checkOutput("t4_store_miss_stalls", 256'(st), 256'd3);
    checkReq("t4_store_alloc", 0, 32'h440, wd);
    ack_delay = 10;
    hold_viol = 0;
    applyStimulus(1, 0, 32'h844, 32'h0, st);
    checkOutput("t4_stalls", 256'(st), 256'd23);
    checkOutput("t4_hold", 256'(hold_viol), 256'd0);
    checkReq("t4_wb", 1, 32'h440, wd);
    checkOutput("t4_wb_word1", {224'd0, wd[63:32]}, {224'd0, 32'h0BAD_F00D});
    checkReq("t4_alloc", 0, 32'h840, wd);
    @(negedge clk_i);
    stray_ack = 1;
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("t4_stray_req", {255'd0, mem_req_o}, 256'd0);
    checkOutput("t4_stray_stall", {255'd0, stall_o}, 256'd0);
    applyStimulus(1, 0, 32'h844, 32'h0, st);
    checkOutput("t4_rehit_stalls", 256'(st), 256'd0);
    checkOutput("t4_no_req", 256'(log_addr.size()), 256'd0);

    $display("[TB] reset mid-allocate");
    resp_hold = 1;
    @(negedge clk_i);
    MemRead_i = 1;
    addr_i = 32'h1040;
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("t5_req", {255'd0, mem_req_o}, 256'd1);
    checkOutput("t5_alloc_we", {255'd0, mem_we_o}, 256'd0);
    checkOutput("t5_alloc_addr", {224'd0, mem_addr_o}, {224'd0, 32'h1040});
    @(negedge clk_i);
    rst_i = 1'b1;
    MemRead_i = 0;
    @(posedge clk_i);
    #1;
    checkOutput("t5_req_drop", {255'd0, mem_req_o}, 256'd0);
    checkOutput("t5_stall_drop", {255'd0, stall_o}, 256'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    stray_ack = 1;
    resp_hold = 0;
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("t5_late_ack_req", {255'd0, mem_req_o}, 256'd0);
    log_we.delete();
    log_addr.delete();
    log_wdata.delete();
    ack_delay = 2;
    applyStimulus(1, 0, 32'h40, 32'h0, st);
    checkOutput("t5_remiss_stalls", 256'(st), 256'd4);
    checkReq("t5_realloc", 0, 32'h40, wd);

    $display("[TB] simultaneous read and write");
    applyStimulus(1, 0, 32'h48, 32'h0, st);
    checkOutput("t6_pre_stalls", 256'(st), 256'd0);
    applyStimulus(1, 1, 32'h48, 32'h0000_00AA, st);
    checkOutput("t6_rw_stalls", 256'(st), 256'd0);
    applyStimulus(1, 0, 32'h48, 32'h0, st);
    checkOutput("t6_load_stalls", 256'(st), 256'd0);

    $display("[TB] same-cycle ack");
    ack_delay = 0;
    applyStimulus(1, 0, 32'h2040, 32'h0, st);
    checkOutput("t7_dirty_stalls", 256'(st), 256'd3);
    checkReq("t7_wb", 1, 32'h40, wd);
    checkOutput("t7_wb_word2", {224'd0, wd[95:64]}, {224'd0, 32'h0000_00AA});
    checkReq("t7_alloc", 0, 32'h2040, wd);
    applyStimulus(1, 0, 32'h48, 32'h0, st);
    checkOutput("t7_clean_stalls", 256'(st), 256'd2);
    checkReq("t7_refetch", 0, 32'h40, wd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
